// File: rtl/irq_controller.sv
// irq_controller: multi-channel external interrupt controller.
// It synchronizes raw interrupt lines and captures each one as an edge or as a level.
// Each channel has a pending latch, and an enable mask gates it for arbitration.
// The lowest eligible index wins.
// A registered machine-external request (g_interrupt) goes to the CSR block.
// A non-nested claim/complete handshake lets the trap handler identify and retire the source.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   irq_in         raw asynchronous interrupt lines (active high)
//   csr_meie       global machine external interrupt enable
//   irq_enable     per-channel enable mask (masks arbitration only)
//   irq_edge_mode  per channel: 1 = rising-edge capture, 0 = level capture
//   claim          one-cycle request for the winning channel ID
//   complete       one-cycle pulse retiring channel complete_id
//   complete_id    channel being completed
//   g_interrupt    registered interrupt request
//   claim_ack      one-cycle pulse, the cycle after claim
//   claim_valid    1 = claim_id names a real source, 0 = spurious claim
//   claim_id       claimed channel (0 when spurious)
//   pending        pending latch state
//   in_service     in-service state
module irq_controller #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               csr_meie,
  input  logic [NUM_IRQ-1:0] irq_enable,
  input  logic [NUM_IRQ-1:0] irq_edge_mode,
  input  logic               claim,
  input  logic               complete,
  input  logic [ID_W-1:0]    complete_id,
  output logic               g_interrupt,
  output logic               claim_ack,
  output logic               claim_valid,
  output logic [ID_W-1:0]    claim_id,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] in_service
);

  localparam logic [NUM_IRQ-1:0] ZERO_V  = {NUM_IRQ{1'b0}};
  localparam logic [ID_W-1:0]    ZERO_ID = {ID_W{1'b0}};

  logic [NUM_IRQ-1:0] sync_r [SYNC_STAGES];
  logic [NUM_IRQ-1:0] hist_r;
  logic [NUM_IRQ-1:0] pending_r;
  logic [NUM_IRQ-1:0] in_service_r;
  logic               g_interrupt_r;
  logic               claim_ack_r;
  logic               claim_valid_r;
  logic [ID_W-1:0]    claim_id_r;

  logic [NUM_IRQ-1:0] sync_s;
  logic [NUM_IRQ-1:0] rise_s;
  logic [NUM_IRQ-1:0] set_edge_s;
  logic [NUM_IRQ-1:0] set_level_s;
  logic [NUM_IRQ-1:0] eligible_s;
  logic [ID_W-1:0]    winner_s;
  logic               win_found_s;
  logic               claim_ok_s;
  logic [NUM_IRQ-1:0] claim_mask_s;
  logic [NUM_IRQ-1:0] cmp_mask_s;
  logic [NUM_IRQ-1:0] pending_nxt_s;
  logic [NUM_IRQ-1:0] in_service_nxt_s;
  logic               g_nxt_s;

  // Input synchronizer chain plus one-cycle history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < SYNC_STAGES; j++) begin
        sync_r[j] <= ZERO_V;
      end
      hist_r <= ZERO_V;
    end else begin
      sync_r[0] <= irq_in;
      for (int j = 1; j < SYNC_STAGES; j++) begin
        sync_r[j] <= sync_r[j-1];
      end
      hist_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Capture conditions and eligibility.
  always_comb begin
    sync_s      = sync_r[SYNC_STAGES-1];
    rise_s      = sync_s & ~hist_r;
    set_edge_s  = irq_edge_mode & rise_s;
    // A level source being serviced must not re-pend until it is completed.
    set_level_s = ~irq_edge_mode & sync_s & ~in_service_r;
    eligible_s  = pending_r & irq_enable;
  end

  // Fixed-priority winner: scan downward so the lowest eligible index is the last one written.
  always_comb begin
    winner_s    = ZERO_ID;
    win_found_s = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      winner_s    = eligible_s[i] ? ID_W'(i) : winner_s;
      win_found_s = win_found_s | eligible_s[i];
    end
  end

  // Claim/complete decode and next-state computation.
  always_comb begin
    // win_found_s covers an enable dropped in the claim cycle itself: the claim is then spurious.
    claim_ok_s = claim & g_interrupt_r & win_found_s;
    for (int i = 0; i < NUM_IRQ; i++) begin
      claim_mask_s[i] = claim_ok_s & (winner_s == ID_W'(i));
      // Out-of-range IDs match no channel and are therefore ignored.
      cmp_mask_s[i]   = complete & (complete_id == ID_W'(i));
    end
    // Level set loses to a same-cycle claim clear; edge set wins over it.
    pending_nxt_s    = ((pending_r | set_level_s) & ~claim_mask_s) | set_edge_s;
    in_service_nxt_s = (in_service_r & ~cmp_mask_s) | claim_mask_s;
    // A successful claim drops the request at once; the next cycle in_service holds it low.
    g_nxt_s = csr_meie & (|eligible_s) & ~(|in_service_r) & ~claim_ok_s;
  end

  // Pending, in-service, request and claim response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r     <= ZERO_V;
      in_service_r  <= ZERO_V;
      g_interrupt_r <= 1'b0;
      claim_ack_r   <= 1'b0;
      claim_valid_r <= 1'b0;
      claim_id_r    <= ZERO_ID;
    end else begin
      pending_r     <= pending_nxt_s;
      in_service_r  <= in_service_nxt_s;
      g_interrupt_r <= g_nxt_s;
      claim_ack_r   <= claim;
      claim_valid_r <= claim_ok_s;
      claim_id_r    <= claim_ok_s ? winner_s : ZERO_ID;
    end
  end

  assign g_interrupt = g_interrupt_r;
  assign claim_ack   = claim_ack_r;
  assign claim_valid = claim_valid_r;
  assign claim_id    = claim_id_r;
  assign pending     = pending_r;
  assign in_service  = in_service_r;

endmodule
